// File: rtl/c3lib_ckmux4_sel_ctl.sv
// Glitch-safe select sequencer for the c3lib 4-to-1 clock mux.
// Gates the muxed clock off, moves the selects, waits for settle, then re-enables.
module c3lib_ckmux4_sel_ctl #(
    parameter int         GATE_WAIT   = 4,
    parameter int         SETTLE_WAIT = 8,
    parameter int         CNT_W       = 4,
    parameter logic [1:0] RST_SEL     = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_vld,
    input  logic [1:0] req_sel,
    output logic       req_rdy,
    input  logic [3:0] ck_ok,
    output logic       ack,
    output logic       err,
    output logic       s0,
    output logic       s1,
    output logic [1:0] cur_sel,
    output logic       ck_gate_en,
    output logic       busy
);

    typedef enum logic [1:0] {INIT, IDLE, GATE_OFF, SETTLE} state_t;

    localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_WAIT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_WAIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       pend_q, pend_d;
    logic             gate_q, gate_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic accept, src_ok, same_sel, cnt_zero;

    assign accept   = req_vld && (state_q == IDLE);
    assign src_ok   = ck_ok[req_sel];
    assign same_sel = (req_sel == sel_q);
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:     if (cnt_zero) state_d = IDLE;
            IDLE:     if (accept && src_ok && !same_sel) state_d = GATE_OFF;
            GATE_OFF: if (cnt_zero) state_d = SETTLE;
            SETTLE:   if (cnt_zero) state_d = IDLE;
            default:  state_d = INIT;
        endcase
    end

    // Selects only move on the GATE_OFF->SETTLE edge, where the gate is already low.
    always_comb begin
        cnt_d  = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
        sel_d  = sel_q;
        pend_d = pend_q;
        gate_d = gate_q;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        case (state_q)
            INIT: if (cnt_zero) gate_d = 1'b1;
            IDLE: begin
                if (accept) begin
                    if (!src_ok) begin
                        err_d = 1'b1;
                    end else if (same_sel) begin
                        ack_d = 1'b1;
                    end else begin
                        gate_d = 1'b0;
                        cnt_d  = GATE_LD;
                        pend_d = req_sel;
                    end
                end
            end
            GATE_OFF: begin
                if (cnt_zero) begin
                    sel_d = pend_q;
                    cnt_d = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    gate_d = 1'b1;
                    ack_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= SETTLE_LD;
            sel_q  <= RST_SEL;
            pend_q <= RST_SEL;
            gate_q <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            pend_q <= pend_d;
            gate_q <= gate_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
        end
    end

    assign req_rdy    = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign ack        = ack_q;
    assign err        = err_q;
    assign s0         = sel_q[0];
    assign s1         = sel_q[1];
    assign cur_sel    = sel_q;
    assign ck_gate_en = gate_q;

endmodule

// File: tb/tb_c3lib_ckmux4_sel_ctl.sv
// Directed bench for c3lib_ckmux4_sel_ctl: reset/INIT, switching, error,
// same-select, back-to-back and mid-sequence reset.
module tb_c3lib_ckmux4_sel_ctl;

    localparam int         GW   = 4;
    localparam int         SW   = 8;
    localparam logic [1:0] RSEL = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_vld = 1'b0;
    logic [1:0] req_sel = 2'b00;
    logic [3:0] ck_ok = 4'hF;
    logic       req_rdy, ack, err, s0, s1, ck_gate_en, busy;
    logic [1:0] cur_sel;

    int errs = 0;
    int checks = 0;

    c3lib_ckmux4_sel_ctl #(
        .GATE_WAIT(GW), .SETTLE_WAIT(SW), .CNT_W(4), .RST_SEL(RSEL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_sel(req_sel),
        .req_rdy(req_rdy), .ck_ok(ck_ok), .ack(ack), .err(err),
        .s0(s0), .s1(s1), .cur_sel(cur_sel), .ck_gate_en(ck_gate_en), .busy(busy)
    );

    always #5 clk = ~clk;

    // Any select movement outside reset must happen with the gate closed.
    logic [1:0] prev_sel = RSEL;
    always @(negedge clk) begin
        if (rst_n && ({s1, s0} != prev_sel)) begin
            checks++;
            if (ck_gate_en !== 1'b0) begin
                errs++;
                $display("FAIL sel_change_gate: sel %0d->%0d with ck_gate_en=%b, need 0",
                         prev_sel, {s1, s0}, ck_gate_en);
            end
        end
        prev_sel = {s1, s0};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        chk("rst_sel", 4'({s1, s0}), 4'(RSEL));
        chk("rst_cur_sel", 4'(cur_sel), 4'(RSEL));
        chk("rst_gate", 4'(ck_gate_en), 4'd0);
        chk("rst_rdy", 4'(req_rdy), 4'd0);
        chk("rst_busy", 4'(busy), 4'd1);
        chk("rst_ack_err", 4'({ack, err}), 4'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= SW; k++) begin
            step();
            chk($sformatf("init_gate_e%0d", k), 4'(ck_gate_en), 4'(k == SW));
            chk($sformatf("init_rdy_e%0d", k), 4'(req_rdy), 4'(k == SW));
            chk($sformatf("init_sel_e%0d", k), 4'(cur_sel), 4'(RSEL));
            chk($sformatf("init_ack_e%0d", k), 4'(ack), 4'd0);
        end
    endtask

    task automatic test_switch();
        logic [1:0] tgt [2];
        logic [1:0] old;
        tgt[0] = 2'd0;
        tgt[1] = 2'd3;
        old = RSEL;
        ck_ok = 4'hF;
        for (int t = 0; t < 2; t++) begin
            req_vld = 1'b1;
            req_sel = tgt[t];
            step();
            req_vld = 1'b0;
            chk("sw_e0_gate", 4'(ck_gate_en), 4'd0);
            chk("sw_e0_rdy", 4'(req_rdy), 4'd0);
            chk("sw_e0_busy", 4'(busy), 4'd1);
            for (int k = 1; k <= GW + SW; k++) begin
                step();
                chk($sformatf("sw%0d_sel_e%0d", t, k), 4'(cur_sel), 4'((k >= GW) ? tgt[t] : old));
                chk($sformatf("sw%0d_gate_e%0d", t, k), 4'(ck_gate_en), 4'(k == GW + SW));
                chk($sformatf("sw%0d_ack_e%0d", t, k), 4'(ack), 4'(k == GW + SW));
            end
            chk("sw_done_rdy", 4'(req_rdy), 4'd1);
            step();
            chk("sw_ack_pulse", 4'(ack), 4'd0);
            chk("sw_gate_hold", 4'(ck_gate_en), 4'd1);
            old = tgt[t];
        end
    endtask

    task automatic test_err();
        ck_ok = 4'b1101;
        req_vld = 1'b1;
        req_sel = 2'd1;
        step();
        req_vld = 1'b0;
        chk("err_pulse", 4'(err), 4'd1);
        chk("err_no_ack", 4'(ack), 4'd0);
        chk("err_sel", 4'(cur_sel), 4'd3);
        chk("err_gate", 4'(ck_gate_en), 4'd1);
        chk("err_busy", 4'(busy), 4'd0);
        chk("err_rdy", 4'(req_rdy), 4'd1);
        step();
        chk("err_clear", 4'(err), 4'd0);
        ck_ok = 4'hF;
    endtask

    task automatic test_same();
        req_vld = 1'b1;
        req_sel = 2'd3;
        step();
        req_vld = 1'b0;
        chk("same_ack", 4'(ack), 4'd1);
        chk("same_no_err", 4'(err), 4'd0);
        chk("same_gate", 4'(ck_gate_en), 4'd1);
        chk("same_busy", 4'(busy), 4'd0);
        step();
        chk("same_ack_clear", 4'(ack), 4'd0);
        chk("same_gate2", 4'(ck_gate_en), 4'd1);
    endtask

    task automatic test_back_to_back();
        req_vld = 1'b1;
        req_sel = 2'd1;
        step();
        for (int k = 1; k <= GW + SW; k++) begin
            step();
            chk($sformatf("b2b1_ack_e%0d", k), 4'(ack), 4'(k == GW + SW));
        end
        chk("b2b1_sel", 4'(cur_sel), 4'd1);
        chk("b2b1_rdy", 4'(req_rdy), 4'd1);
        req_sel = 2'd2;
        step();
        chk("b2b2_accepted_gate", 4'(ck_gate_en), 4'd0);
        chk("b2b2_accepted_busy", 4'(busy), 4'd1);
        chk("b2b2_ack_clear", 4'(ack), 4'd0);
        for (int k = 1; k <= GW + SW; k++) begin
            step();
            chk($sformatf("b2b2_sel_e%0d", k), 4'(cur_sel), 4'((k >= GW) ? 2'd2 : 2'd1));
            chk($sformatf("b2b2_ack_e%0d", k), 4'(ack), 4'(k == GW + SW));
        end
        req_vld = 1'b0;
        step();
        chk("b2b_idle", 4'(busy), 4'd0);
    endtask

    task automatic test_reset_mid();
        req_vld = 1'b1;
        req_sel = 2'd0;
        step();
        req_vld = 1'b0;
        for (int k = 1; k <= GW + 1; k++) step();
        chk("mid_in_settle_sel", 4'(cur_sel), 4'd0);
        chk("mid_in_settle_gate", 4'(ck_gate_en), 4'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", 4'(cur_sel), 4'(RSEL));
        chk("mid_rst_gate", 4'(ck_gate_en), 4'd0);
        chk("mid_rst_busy", 4'(busy), 4'd1);
        chk("mid_rst_rdy", 4'(req_rdy), 4'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("mid_rst_ack_%0d", k), 4'({ack, err}), 4'd0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= SW; k++) begin
            step();
            chk($sformatf("reinit_gate_e%0d", k), 4'(ck_gate_en), 4'(k == SW));
            chk($sformatf("reinit_ack_e%0d", k), 4'(ack), 4'd0);
            chk($sformatf("reinit_sel_e%0d", k), 4'(cur_sel), 4'(RSEL));
        end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_err();
        test_same();
        test_back_to_back();
        test_reset_mid();
        step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
